// File: rtl/uci_commander_if.sv
// Shared types and the bundled port interface for uci_commander.
//
// uci_pkg
//   special_t : move annotation (promotion piece or unknown suffix)
//   square_t  : board square, col 0..7 = a..h, row 0..7 = 1..8
//   move_t    : {src, dst, special}
//
// uci_commander_if
//   Host side (master) drives moves, control pulses, the command-stream ready and
//   the engine response stream. Design side (slave) drives the command stream,
//   decoded engine replies and status.
//   move_in / move_in_valid / move_in_ready        : history append handshake
//   new_game_in, start_in                          : control pulses
//   char_out / char_out_valid / char_out_ready     : command characters to the engine
//   char_in / char_in_valid / char_in_ready        : response characters from the engine
//   best_move_out / best_move_out_valid            : decoded "bestmove" reply
//   busy, move_count                               : status
package uci_pkg;
    typedef enum logic [2:0] {
        SPECIAL_NONE    = 3'd0,
        PROMOTE_KNIGHT  = 3'd1,
        PROMOTE_BISHOP  = 3'd2,
        PROMOTE_ROOK    = 3'd3,
        PROMOTE_QUEEN   = 3'd4,
        SPECIAL_UNKNOWN = 3'd5
    } special_t;

    typedef struct packed {
        logic [2:0] col;
        logic [2:0] row;
    } square_t;

    typedef struct packed {
        square_t  src;
        square_t  dst;
        special_t special;
    } move_t;
endpackage

interface uci_commander_if;
    import uci_pkg::*;

    move_t      move_in;
    logic       move_in_valid;
    logic       move_in_ready;
    logic       new_game_in;
    logic       start_in;
    logic [7:0] char_out;
    logic       char_out_valid;
    logic       char_out_ready;
    logic [7:0] char_in;
    logic       char_in_valid;
    logic       char_in_ready;
    move_t      best_move_out;
    logic       best_move_out_valid;
    logic       busy;
    logic [6:0] move_count;

    modport slave (
        input  move_in, move_in_valid, new_game_in, start_in,
               char_out_ready, char_in, char_in_valid,
        output move_in_ready, char_out, char_out_valid, char_in_ready,
               best_move_out, best_move_out_valid, busy, move_count
    );

    modport master (
        output move_in, move_in_valid, new_game_in, start_in,
               char_out_ready, char_in, char_in_valid,
        input  move_in_ready, char_out, char_out_valid, char_in_ready,
               best_move_out, best_move_out_valid, busy, move_count
    );
endinterface

// File: rtl/uci_commander.sv
// uci_commander: keeps a move history, streams a UCI
// "position startpos [moves ...]\ngo\n" command to a chess engine on request, and
// parses the engine's response stream for "bestmove <move>" lines.
//
// Ports
//   clk_in  : sole clock
//   rst_in  : synchronous active-high reset
//   bus     : uci_commander_if.slave (see interface file for the signal list)
//
// Parameter
//   MAX_MOVES : history depth, 1..64
module uci_commander
    import uci_pkg::*;
#(
    parameter int MAX_MOVES = 16
) (
    input  logic           clk_in,
    input  logic           rst_in,
    uci_commander_if.slave bus
);

    localparam int         IW      = (MAX_MOVES > 1) ? $clog2(MAX_MOVES) : 1;
    localparam logic [6:0] MAX_CNT = 7'(MAX_MOVES);

    localparam logic [8*17-1:0] PFX_STR = "position startpos";
    localparam logic [8*6-1:0]  KW_STR  = " moves";
    localparam logic [8*3-1:0]  GO_STR  = {"go", 8'h0A};
    localparam logic [8*9-1:0]  BM_STR  = "bestmove ";
    localparam logic [7:0]      LF      = 8'h0A;
    localparam logic [7:0]      SP      = 8'h20;

    typedef enum logic [2:0] {IDLE, PREFIX, MOVES_KW, MOVE, NL, GO, WAIT_BEST} tx_state_t;
    typedef enum logic [1:0] {RX_LINE, RX_TOKEN, RX_SKIP} rx_state_t;

    // ---------------------------------------------------------------- helpers
    function automatic logic is_promo(input special_t s);
        return (s == PROMOTE_KNIGHT) || (s == PROMOTE_BISHOP) ||
               (s == PROMOTE_ROOK)   || (s == PROMOTE_QUEEN);
    endfunction

    function automatic logic [7:0] promo_char(input special_t s);
        case (s)
            PROMOTE_KNIGHT: return "n";
            PROMOTE_BISHOP: return "b";
            PROMOTE_ROOK:   return "r";
            default:        return "q";
        endcase
    endfunction

    function automatic logic col_ok(input logic [7:0] c);
        return (c >= "a") && (c <= "h");
    endfunction

    function automatic logic row_ok(input logic [7:0] c);
        return (c >= "1") && (c <= "8");
    endfunction

    function automatic logic [2:0] offset3(input logic [7:0] c, input logic [7:0] base);
        logic [7:0] d;
        d = c - base;
        return d[2:0];
    endfunction

    function automatic special_t suffix_special(input logic [7:0] c);
        case (c)
            "n":     return PROMOTE_KNIGHT;
            "b":     return PROMOTE_BISHOP;
            "r":     return PROMOTE_ROOK;
            "q":     return PROMOTE_QUEEN;
            default: return SPECIAL_UNKNOWN;
        endcase
    endfunction

    // ---------------------------------------------------------------- state
    tx_state_t  state_q;
    logic [4:0] idx_q;       // next character to load within the current section
    logic [6:0] midx_q;      // history entry being transmitted
    logic [6:0] count_q;
    logic [7:0] char_q;
    logic       char_vld_q;
    move_t      hist_q [MAX_MOVES];

    rx_state_t  rx_state_q;
    logic [63:0] shift_q;    // previous eight chars; with the incoming one forms the 9-char window
    logic [3:0] lpos_q;      // chars seen on the current line, saturating at 9
    logic [7:0] tok_q [5];
    logic [2:0] tlen_q;      // token length; 6 marks an over-long token
    move_t      bm_q;
    logic       bm_vld_q;

    // ---------------------------------------------------------------- transmit character generator
    move_t      cur_move;
    logic [7:0] tx_char;
    logic       tx_have;
    logic       tx_last;
    logic       tx_load;

    assign cur_move = hist_q[midx_q[IW-1:0]];

    always_comb begin
        tx_char = 8'h00;
        tx_have = 1'b0;
        tx_last = 1'b0;
        case (state_q)
            PREFIX: begin
                tx_have = 1'b1;
                tx_char = PFX_STR[8*(16 - int'(idx_q)) +: 8];
                tx_last = (idx_q == 5'd16);
            end
            MOVES_KW: begin
                tx_have = 1'b1;
                tx_char = KW_STR[8*(5 - int'(idx_q)) +: 8];
                tx_last = (idx_q == 5'd5);
            end
            MOVE: begin
                tx_have = 1'b1;
                case (idx_q)
                    5'd0:    tx_char = SP;
                    5'd1:    tx_char = 8'h61 + {5'd0, cur_move.src.col};
                    5'd2:    tx_char = 8'h31 + {5'd0, cur_move.src.row};
                    5'd3:    tx_char = 8'h61 + {5'd0, cur_move.dst.col};
                    5'd4:    tx_char = 8'h31 + {5'd0, cur_move.dst.row};
                    default: tx_char = promo_char(cur_move.special);
                endcase
                tx_last = (idx_q == 5'd5) || ((idx_q == 5'd4) && !is_promo(cur_move.special));
            end
            NL: begin
                tx_have = 1'b1;
                tx_char = LF;
                tx_last = 1'b1;
            end
            GO: begin
                // idx 3 is a parking slot: nothing left to load, wait for the final LF to drain
                tx_have = (idx_q < 5'd3);
                tx_char = GO_STR[8*(2 - int'(idx_q)) +: 8];
                tx_last = (idx_q == 5'd2);
            end
            default: ;
        endcase
    end

    // Load the next character whenever the output register is empty or being consumed.
    assign tx_load = tx_have && (!char_vld_q || bus.char_out_ready);

    // ---------------------------------------------------------------- receive token decode
    logic [7:0] rx_c;
    logic       rx_term;
    logic       rx_ok;
    logic       rx_hit;
    move_t      rx_move;

    assign rx_c    = bus.char_in;
    assign rx_term = (rx_state_q == RX_TOKEN) && ((rx_c == SP) || (rx_c == LF));

    always_comb begin
        rx_ok = ((tlen_q == 3'd4) || (tlen_q == 3'd5)) &&
                col_ok(tok_q[0]) && row_ok(tok_q[1]) &&
                col_ok(tok_q[2]) && row_ok(tok_q[3]);
        rx_move.src.col = offset3(tok_q[0], 8'h61);
        rx_move.src.row = offset3(tok_q[1], 8'h31);
        rx_move.dst.col = offset3(tok_q[2], 8'h61);
        rx_move.dst.row = offset3(tok_q[3], 8'h31);
        rx_move.special = (tlen_q == 3'd4) ? SPECIAL_NONE : suffix_special(tok_q[4]);
    end

    assign rx_hit = bus.char_in_valid && rx_term && rx_ok;

    // ---------------------------------------------------------------- history control
    logic auto_app;
    logic user_app;
    logic new_game;

    // Auto-append only happens in WAIT_BEST, so it can never race a user append;
    // the extra term keeps move_in_ready honest if that ever changes.
    assign auto_app          = rx_hit && (state_q == WAIT_BEST) && (count_q < MAX_CNT);
    assign new_game          = bus.new_game_in && (state_q == IDLE);
    assign bus.move_in_ready = (state_q == IDLE) && (count_q < MAX_CNT) && !auto_app;
    assign user_app          = bus.move_in_valid && bus.move_in_ready && !new_game;

    always_ff @(posedge clk_in) begin
        if (auto_app) begin
            hist_q[count_q[IW-1:0]] <= rx_move;
        end else if (user_app) begin
            hist_q[count_q[IW-1:0]] <= bus.move_in;
        end
    end

    // ---------------------------------------------------------------- transmit FSM
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            midx_q     <= '0;
            count_q    <= '0;
            char_q     <= '0;
            char_vld_q <= 1'b0;
        end else begin
            if (new_game) begin
                count_q <= '0;
            end else if (auto_app || user_app) begin
                count_q <= count_q + 7'd1;
            end

            if (tx_load) begin
                char_q     <= tx_char;
                char_vld_q <= 1'b1;
                idx_q      <= tx_last ? 5'd0 : idx_q + 5'd1;
            end else if (char_vld_q && bus.char_out_ready) begin
                char_vld_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (bus.start_in) begin
                        state_q <= PREFIX;
                        idx_q   <= '0;
                    end
                end
                PREFIX: begin
                    if (tx_load && tx_last) begin
                        state_q <= (count_q == 7'd0) ? NL : MOVES_KW;
                    end
                end
                MOVES_KW: begin
                    if (tx_load && tx_last) begin
                        state_q <= MOVE;
                        midx_q  <= '0;
                    end
                end
                MOVE: begin
                    if (tx_load && tx_last) begin
                        if (midx_q + 7'd1 == count_q) begin
                            state_q <= NL;
                        end else begin
                            midx_q <= midx_q + 7'd1;
                        end
                    end
                end
                NL: begin
                    if (tx_load) begin
                        state_q <= GO;
                    end
                end
                GO: begin
                    if (tx_load && tx_last) begin
                        idx_q <= 5'd3;
                    end else if ((idx_q == 5'd3) && (!char_vld_q || bus.char_out_ready)) begin
                        state_q <= WAIT_BEST;
                    end
                end
                WAIT_BEST: begin
                    if (rx_hit) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- receive parser
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_state_q <= RX_LINE;
            shift_q    <= '0;
            lpos_q     <= '0;
            tlen_q     <= '0;
            bm_q       <= '0;
            bm_vld_q   <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                tok_q[i] <= '0;
            end
        end else begin
            bm_vld_q <= rx_hit;
            if (rx_hit) begin
                bm_q <= rx_move;
            end

            if (bus.char_in_valid) begin
                shift_q <= {shift_q[55:0], rx_c};
                if (rx_c == LF) begin
                    lpos_q <= '0;
                end else if (lpos_q != 4'd9) begin
                    lpos_q <= lpos_q + 4'd1;
                end

                case (rx_state_q)
                    RX_LINE: begin
                        // Only a line that begins with "bestmove " opens a token.
                        if ((lpos_q == 4'd8) && ({shift_q, rx_c} == BM_STR)) begin
                            rx_state_q <= RX_TOKEN;
                            tlen_q     <= '0;
                        end
                    end
                    RX_TOKEN: begin
                        if (rx_term) begin
                            rx_state_q <= (rx_c == LF) ? RX_LINE : RX_SKIP;
                        end else begin
                            if (tlen_q < 3'd5) begin
                                tok_q[tlen_q] <= rx_c;
                            end
                            if (tlen_q < 3'd6) begin
                                tlen_q <= tlen_q + 3'd1;
                            end
                        end
                    end
                    RX_SKIP: begin
                        if (rx_c == LF) begin
                            rx_state_q <= RX_LINE;
                        end
                    end
                    default: rx_state_q <= RX_LINE;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.char_out            = char_q;
    assign bus.char_out_valid      = char_vld_q;
    assign bus.char_in_ready       = 1'b1;
    assign bus.best_move_out       = bm_q;
    assign bus.best_move_out_valid = bm_vld_q;
    assign bus.busy                = (state_q != IDLE);
    assign bus.move_count          = count_q;

endmodule
